// File: rtl/sda_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sda_reg_bus_arbiter
//
// Shares one slave-side simple register bus between NumMasters register
// masters (e.g. a host AXI-Lite bridge and an on-chip debug/self-test master).
// Round-robin grant, one transaction in flight, request captured into
// registers at grant time. A WAIT-state timeout returns an error to the
// master, so a missing slave cannot hang the bus.
//
// Ports:
//   clk, srst            clock, synchronous active-high reset
//   mReq/mWriteEn        per-master request / write enable (bit i = master i)
//   mAddr/mWData         per-master address / write data (slice i = master i)
//   mAck/mErr            one-cycle completion pulse / timeout flag to grantee
//   mRData               per-master read data, valid with mAck, zero otherwise
//   sReq/sWriteEn        slave request / write enable
//   sAddr/sWData         slave address / write data
//   sAck/sRData          slave single-cycle ack / read data
//   busy                 high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module sda_reg_bus_arbiter #(
    parameter int NumMasters    = 2,
    parameter int RegAddrWidth  = 8,
    parameter int TimeoutCycles = 255
) (
    input  logic                                clk,
    input  logic                                srst,
    input  logic [NumMasters-1:0]               mReq,
    input  logic [NumMasters-1:0]               mWriteEn,
    input  logic [NumMasters*RegAddrWidth-1:0]  mAddr,
    input  logic [NumMasters*32-1:0]            mWData,
    output logic [NumMasters-1:0]               mAck,
    output logic [NumMasters*32-1:0]            mRData,
    output logic [NumMasters-1:0]               mErr,
    output logic                                sReq,
    output logic                                sWriteEn,
    output logic [RegAddrWidth-1:0]             sAddr,
    output logic [31:0]                         sWData,
    input  logic                                sAck,
    input  logic [31:0]                         sRData,
    output logic                                busy
);

    localparam int              IdxW        = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam logic [IdxW-1:0] LastIdx     = IdxW'(NumMasters - 1);
    localparam bit              TimeoutEn   = (TimeoutCycles != 0);
    // Counter value seen during the last permitted WAIT cycle.
    localparam logic [15:0]     TimeoutLast = TimeoutEn ? 16'(TimeoutCycles - 1) : 16'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Registered state and outputs
    state_t                         state_r;
    logic [IdxW-1:0]                lastGrant_r;
    logic [15:0]                    count_r;
    logic                           justAcked_r;
    logic                           sReq_r;
    logic                           sWriteEn_r;
    logic [RegAddrWidth-1:0]        sAddr_r;
    logic [31:0]                    sWData_r;
    logic [NumMasters-1:0]          mAck_r;
    logic [NumMasters-1:0]          mErr_r;
    logic [NumMasters*32-1:0]       mRData_r;
    logic                           busy_r;

    // Next-state / combinational signals
    state_t                         nextState_s;
    logic [IdxW-1:0]                lastGrantNext_s;
    logic [15:0]                    countNext_s;
    logic                           sReqNext_s;
    logic                           sWriteEnNext_s;
    logic [RegAddrWidth-1:0]        sAddrNext_s;
    logic [31:0]                    sWDataNext_s;
    logic [NumMasters-1:0]          mAckNext_s;
    logic [NumMasters-1:0]          mErrNext_s;
    logic [NumMasters*32-1:0]       mRDataNext_s;
    logic [NumMasters-1:0]          reqMasked_s;
    logic                           grantFound_s;
    logic [IdxW-1:0]                grantIdx_s;
    logic [IdxW-1:0]                candIdx_s;
    int                             searchPos_s;
    logic                           timeoutHit_s;
    logic                           ackHit_s;
    logic                           errHit_s;
    logic [31:0]                    rdataCap_s;

    assign mAck     = mAck_r;
    assign mErr     = mErr_r;
    assign mRData   = mRData_r;
    assign sReq     = sReq_r;
    assign sWriteEn = sWriteEn_r;
    assign sAddr    = sAddr_r;
    assign sWData   = sWData_r;
    assign busy     = busy_r;

    assign timeoutHit_s = TimeoutEn && (count_r == TimeoutLast);

    // Round-robin pick: mask the master just served (its request is still high
    // for one cycle after mAck), then search upward from lastGrant_r + 1.
    always_comb begin
        reqMasked_s = mReq;
        if (justAcked_r) begin
            reqMasked_s[lastGrant_r] = 1'b0;
        end else begin
            reqMasked_s = mReq;
        end
        grantFound_s = 1'b0;
        grantIdx_s   = '0;
        candIdx_s    = '0;
        searchPos_s  = 0;
        for (int k = 1; k <= NumMasters; k++) begin
            searchPos_s = int'(lastGrant_r) + k;
            if (searchPos_s >= NumMasters) begin
                searchPos_s = searchPos_s - NumMasters;
            end else begin
                searchPos_s = searchPos_s;
            end
            candIdx_s = IdxW'(searchPos_s);
            if (!grantFound_s && reqMasked_s[candIdx_s]) begin
                grantFound_s = 1'b1;
                grantIdx_s   = candIdx_s;
            end else begin
                grantFound_s = grantFound_s;
            end
        end
    end

    // FSM next-state and slave-side output values.
    always_comb begin
        nextState_s     = state_r;
        lastGrantNext_s = lastGrant_r;
        countNext_s     = count_r;
        sReqNext_s      = sReq_r;
        sWriteEnNext_s  = sWriteEn_r;
        sAddrNext_s     = sAddr_r;
        sWDataNext_s    = sWData_r;
        ackHit_s        = 1'b0;
        errHit_s        = 1'b0;
        rdataCap_s      = 32'd0;
        case (state_r)
            IDLE: begin
                if (grantFound_s) begin
                    nextState_s     = WAIT;
                    lastGrantNext_s = grantIdx_s;
                    countNext_s     = 16'd0;
                    sReqNext_s      = 1'b1;
                    sWriteEnNext_s  = mWriteEn[grantIdx_s];
                    sAddrNext_s     = mAddr[int'(grantIdx_s)*RegAddrWidth +: RegAddrWidth];
                    sWDataNext_s    = mWData[int'(grantIdx_s)*32 +: 32];
                end else begin
                    nextState_s     = IDLE;
                end
            end
            WAIT: begin
                countNext_s = count_r + 16'd1;
                // A slave ack wins over a timeout in the same cycle.
                if (sAck) begin
                    nextState_s    = ACK;
                    ackHit_s       = 1'b1;
                    rdataCap_s     = sRData;
                    sReqNext_s     = 1'b0;
                    sWriteEnNext_s = 1'b0;
                    sAddrNext_s    = '0;
                    sWDataNext_s   = 32'd0;
                end else if (timeoutHit_s) begin
                    nextState_s    = ACK;
                    ackHit_s       = 1'b1;
                    errHit_s       = 1'b1;
                    sReqNext_s     = 1'b0;
                    sWriteEnNext_s = 1'b0;
                    sAddrNext_s    = '0;
                    sWDataNext_s   = 32'd0;
                end else begin
                    nextState_s    = WAIT;
                end
            end
            ACK: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s    = IDLE;
                sReqNext_s     = 1'b0;
                sWriteEnNext_s = 1'b0;
                sAddrNext_s    = '0;
                sWDataNext_s   = 32'd0;
            end
        endcase
    end

    // Master-side response values: only the grantee's slice is ever non-zero.
    always_comb begin
        mAckNext_s   = '0;
        mErrNext_s   = '0;
        mRDataNext_s = '0;
        for (int i = 0; i < NumMasters; i++) begin
            if (ackHit_s && (lastGrant_r == IdxW'(i))) begin
                mAckNext_s[i]              = 1'b1;
                mErrNext_s[i]              = errHit_s;
                mRDataNext_s[i*32 +: 32]   = rdataCap_s;
            end else begin
                mAckNext_s[i]              = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r     <= IDLE;
            lastGrant_r <= LastIdx;
            count_r     <= 16'd0;
            justAcked_r <= 1'b0;
            sReq_r      <= 1'b0;
            sWriteEn_r  <= 1'b0;
            sAddr_r     <= '0;
            sWData_r    <= 32'd0;
            mAck_r      <= '0;
            mErr_r      <= '0;
            mRData_r    <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= nextState_s;
            lastGrant_r <= lastGrantNext_s;
            count_r     <= countNext_s;
            justAcked_r <= (state_r == ACK);
            sReq_r      <= sReqNext_s;
            sWriteEn_r  <= sWriteEnNext_s;
            sAddr_r     <= sAddrNext_s;
            sWData_r    <= sWDataNext_s;
            mAck_r      <= mAckNext_s;
            mErr_r      <= mErrNext_s;
            mRData_r    <= mRDataNext_s;
            busy_r      <= (nextState_s != IDLE);
        end
    end

endmodule

// File: tb/tb_sda_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sda_reg_bus_arbiter (3 masters, 4-cycle timeout).
// Directed scenarios followed by a randomized phase checked against a
// transaction-level reference model (round-robin pick, latency arithmetic).
// -----------------------------------------------------------------------------
module tb_sda_reg_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 8;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              srst;
    logic [NM-1:0]     mReq, mWriteEn;
    logic [NM*AW-1:0]  mAddr;
    logic [NM*32-1:0]  mWData;
    logic [NM-1:0]     mAck, mErr;
    logic [NM*32-1:0]  mRData;
    logic              sReq, sWriteEn;
    logic [AW-1:0]     sAddr;
    logic [31:0]       sWData;
    logic              sAck;
    logic [31:0]       sRData;
    logic              busy;

    int          nCmp = 0;
    int          nBad = 0;
    int          cyc  = 0;
    // Slave model controls
    int          slaveLat  = 2;
    bit          slaveOn   = 1'b1;
    logic [31:0] slaveData = 32'd0;
    bit          strayAck  = 1'b0;
    int          age       = 0;

    // Contention bookkeeping
    int ackOrder[$];
    int ackAt[$];
    int base;

    // Reference model state for the randomized phase
    logic [NM-1:0]    reqS, weS, masked, expAck, expErr;
    logic [NM*AW-1:0] addrS;
    logic [NM*32-1:0] wdS, expRD;
    int          lastG, maskM, idleFrom, ackCyc, curM, idx, dropped;
    bit          inFlight, curErr, found;
    logic [31:0] curData;

    sda_reg_bus_arbiter #(
        .NumMasters   (NM),
        .RegAddrWidth (AW),
        .TimeoutCycles(TO)
    ) dut (
        .clk     (clk),
        .srst    (srst),
        .mReq    (mReq),
        .mWriteEn(mWriteEn),
        .mAddr   (mAddr),
        .mWData  (mWData),
        .mAck    (mAck),
        .mRData  (mRData),
        .mErr    (mErr),
        .sReq    (sReq),
        .sWriteEn(sWriteEn),
        .sAddr   (sAddr),
        .sWData  (sWData),
        .sAck    (sAck),
        .sRData  (sRData),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: acks slaveLat cycles after sReq rises; optional stray ack.
    initial begin
        sAck   = 1'b0;
        sRData = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            sAck   = 1'b0;
            sRData = 32'd0;
            if (strayAck) begin
                sAck     = 1'b1;
                sRData   = 32'hDEAD_BEEF;
                strayAck = 1'b0;
            end else if (sReq) begin
                if (slaveOn && age == slaveLat) begin
                    sAck   = 1'b1;
                    sRData = slaveData;
                end
                age++;
            end else begin
                age = 0;
            end
        end
    end

    task automatic newReq(input int i);
        mReq[i]             = 1'b1;
        mWriteEn[i]         = 1'($urandom_range(0, 1));
        mAddr[i*AW +: AW]   = AW'($urandom);
        mWData[i*32 +: 32]  = $urandom;
    endtask

    // One request from master m; cycle 0 is now, mAck expected at ackAt.
    task automatic runTxn(input int m, input bit we, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input int lat, input bit on,
                          input logic [31:0] rd, input int ackAtCyc, input bit expE,
                          input string tag);
        logic [NM*32-1:0] e;
        logic [NM-1:0]    oh;
        mReq = '0;
        mReq[m] = 1'b1;
        mWriteEn[m] = we;
        mAddr[m*AW +: AW] = addr;
        mWData[m*32 +: 32] = wd;
        slaveLat = lat;
        slaveOn = on;
        slaveData = rd;
        for (int t = 1; t <= ackAtCyc + 1; t++) begin
            tick();
            oh = '0;
            oh[m] = 1'b1;
            e = '0;
            if (t == ackAtCyc && !expE) e[m*32 +: 32] = rd;
            chk({tag, "_sReq"}, sReq, (t < ackAtCyc));
            if (t < ackAtCyc) begin
                chk({tag, "_sWriteEn"}, sWriteEn, we);
                chk({tag, "_sAddr"}, sAddr, addr);
                chk({tag, "_sWData"}, sWData, wd);
            end
            chk({tag, "_mAck"}, mAck, (t == ackAtCyc) ? oh : '0);
            chk({tag, "_mErr"}, mErr, (t == ackAtCyc && expE) ? oh : '0);
            chk({tag, "_mRData"}, mRData, e);
            chk({tag, "_busy"}, busy, (t <= ackAtCyc));
            if (t == ackAtCyc) mReq[m] = 1'b0;
        end
    endtask

    initial begin
        srst = 1'b1;
        mReq = '0; mWriteEn = '0; mAddr = '0; mWData = '0;
        tick();
        tick();
        chk("rst_mAck", mAck, 0);
        chk("rst_mErr", mErr, 0);
        chk("rst_mRData", mRData, 0);
        chk("rst_sReq", sReq, 0);
        chk("rst_sWriteEn", sWriteEn, 0);
        chk("rst_sAddr", sAddr, 0);
        chk("rst_sWData", sWData, 0);
        chk("rst_busy", busy, 0);
        srst = 1'b0;
        tick();

        // Read, master 0, ack latency 2 -> mAck at cycle 4.
        runTxn(0, 1'b0, 8'h00, 32'd0, 2, 1'b1, 32'h0000_000C, 4, 1'b0, "rd0");
        // Write, master 1, latency 1 -> mAck at cycle 3, read data zero.
        runTxn(1, 1'b1, 8'h04, 32'd1, 1, 1'b1, 32'd0, 3, 1'b0, "wr1");
        // Timeout, master 2: sReq for 4 WAIT cycles, mAck+mErr at cycle 5.
        runTxn(2, 1'b0, 8'h10, 32'd0, 9, 1'b0, 32'd0, 5, 1'b1, "to2");
        // A stray ack after the timeout must not produce a response.
        strayAck = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("stray_mAck", mAck, 0);
            chk("stray_mRData", mRData, 0);
            chk("stray_busy", busy, 0);
        end
        // Ack on the timeout cycle: data returned, no error.
        runTxn(0, 1'b0, 8'h20, 32'd0, 3, 1'b1, 32'h5A5A_1234, 5, 1'b0, "coin");

        // Reset while the slave is acking: no mAck, back to reset state.
        mReq = '0;
        mReq[1] = 1'b1;
        mAddr[1*AW +: AW] = 8'h30;
        slaveLat = 2; slaveOn = 1'b1; slaveData = 32'h1111_1111;
        tick();
        chk("rstw_sReq_on", sReq, 1);
        tick();
        tick();
        srst = 1'b1;
        tick();
        chk("rstw_sReq", sReq, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_mAck", mAck, 0);
        chk("rstw_mErr", mErr, 0);
        srst = 1'b0;

        // Contention from reset: both request continuously -> 0,1,0,1 every L+3.
        mReq = 3'b011;
        slaveLat = 1; slaveData = 32'h0000_00A5;
        base = cyc;
        for (int t = 0; t < 40 && ackOrder.size() < 4; t++) begin
            tick();
            if (mAck != '0) begin
                chk("cont_onehot", $countones(mAck), 1);
                for (int i = 0; i < NM; i++) begin
                    if (mAck[i]) begin
                        ackOrder.push_back(i);
                        ackAt.push_back(cyc);
                    end
                end
            end
        end
        chk("cont_count", ackOrder.size(), 4);
        for (int i = 0; i < ackOrder.size() && i < 4; i++) begin
            chk("cont_order", ackOrder[i], i % 2);
            chk("cont_cycle", ackAt[i], base + 3 + 4 * i);
        end
        mReq = '0;

        // Randomized phase against the transaction-level model.
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
        lastG = NM - 1; maskM = -1; inFlight = 1'b0; idleFrom = cyc;
        slaveLat = $urandom_range(1, 5); slaveData = $urandom; slaveOn = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            tick();
            reqS = mReq; weS = mWriteEn; addrS = mAddr; wdS = mWData;
            if (!inFlight && (cyc - 1) >= idleFrom) begin
                masked = reqS;
                if (maskM >= 0 && (cyc - 1) == idleFrom) masked[maskM] = 1'b0;
                if (masked != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= NM; k++) begin
                        idx = (lastG + k) % NM;
                        if (!found && masked[idx]) begin
                            found = 1'b1;
                            curM = idx;
                        end
                    end
                    lastG = curM;
                    inFlight = 1'b1;
                    if (slaveLat <= TO - 1) begin
                        ackCyc = cyc + slaveLat + 1; curErr = 1'b0; curData = slaveData;
                    end else begin
                        ackCyc = cyc + TO; curErr = 1'b1; curData = 32'd0;
                    end
                    chk("rnd_sAddr", sAddr, addrS[curM*AW +: AW]);
                    chk("rnd_sWriteEn", sWriteEn, weS[curM]);
                    chk("rnd_sWData", sWData, wdS[curM*32 +: 32]);
                end
            end
            expAck = '0; expErr = '0; expRD = '0;
            if (inFlight && cyc == ackCyc) begin
                expAck[curM] = 1'b1;
                expErr[curM] = curErr;
                expRD[curM*32 +: 32] = curData;
            end
            chk("rnd_mAck", mAck, expAck);
            chk("rnd_mErr", mErr, expErr);
            chk("rnd_mRData", mRData, expRD);
            chk("rnd_sReq", sReq, (inFlight && cyc < ackCyc));
            chk("rnd_busy", busy, inFlight);
            dropped = -1;
            if (inFlight && cyc == ackCyc) begin
                inFlight = 1'b0;
                idleFrom = cyc + 1;
                maskM = curM;
                slaveLat = $urandom_range(1, 5);
                slaveData = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    newReq(curM);
                end else begin
                    mReq[curM] = 1'b0;
                    dropped = curM;
                end
            end
            for (int i = 0; i < NM; i++) begin
                if (!mReq[i] && i != dropped && $urandom_range(0, 3) == 0) newReq(i);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
